// File: rtl/ray_sched_pkg.sv
// rtl/ray_sched_pkg.sv - shared types for the ray scheduler
package ray_sched_pkg;

   localparam int RAY_W    = 192;
   localparam int ID_MAX_W = 32;

   typedef logic [RAY_W-1:0] ray_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} unit_state_t;

   // Tag is stored zero-extended to the widest supported ID; the top slices ID_W back out.
   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic                hit;
      logic [31:0]         t;
      logic [31:0]         tri_index;
   } result_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; pointer moves one past the winner on advance
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req_i,
   input  logic             advance_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             any_o
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [IDX_W-1:0] cand;
   int               j;

   // Scan from the farthest offset back to the pointer so the nearest request wins last.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      j           = 0;
      cand        = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(ptr_q) + i;
         if (j >= N) begin
            j = j - N;
         end
         cand = IDX_W'(j);
         if (req_i[cand]) begin
            grant_o       = '0;
            grant_o[cand] = 1'b1;
            grant_idx_o   = cand;
            any_o         = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i && any_o) begin
         ptr_d = (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ray_scheduler.sv
// rtl/ray_scheduler.sv - dispatches tagged rays to parallel intersection units
// Per-unit IDLE/RUN/DONE slots with round-robin dispatch and round-robin result return.
module ray_scheduler
   import ray_sched_pkg::*;
#(
   parameter int NUM_UNITS = 4,
   parameter int ID_W      = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [RAY_W-1:0]           i_ray,
   input  logic [ID_W-1:0]            i_ray_id,
   input  logic [31:0]                cfg_baseaddr,
   input  logic [31:0]                cfg_tri_cnt,
   output logic [NUM_UNITS-1:0]       o_unit_ivalid,
   output logic [NUM_UNITS*RAY_W-1:0] o_unit_ray,
   output logic [NUM_UNITS*32-1:0]    o_unit_baseaddr,
   output logic [NUM_UNITS*32-1:0]    o_unit_tri_cnt,
   input  logic [NUM_UNITS-1:0]       i_unit_finish,
   input  logic [NUM_UNITS-1:0]       i_unit_hit,
   input  logic [NUM_UNITS*32-1:0]    i_unit_t,
   input  logic [NUM_UNITS*32-1:0]    i_unit_tri_index,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [ID_W-1:0]            o_ray_id,
   output logic                       o_hit,
   output logic [31:0]                o_t,
   output logic [31:0]                o_tri_index,
   output logic                       o_busy,
   output logic                       o_err
);

   localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   unit_state_t          state_q [NUM_UNITS];
   unit_state_t          state_d [NUM_UNITS];
   ray_t                 ray_q   [NUM_UNITS];
   ray_t                 ray_d   [NUM_UNITS];
   logic [31:0]          base_q  [NUM_UNITS];
   logic [31:0]          base_d  [NUM_UNITS];
   logic [31:0]          cnt_q   [NUM_UNITS];
   logic [31:0]          cnt_d   [NUM_UNITS];
   result_t              res_q   [NUM_UNITS];
   result_t              res_d   [NUM_UNITS];
   logic [NUM_UNITS-1:0] ivalid_q, ivalid_d;
   result_t              out_q, out_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;

   logic [NUM_UNITS-1:0] idle_vec, done_vec;
   logic [NUM_UNITS-1:0] disp_gnt, res_gnt;
   logic [IDX_W-1:0]     disp_idx, res_idx;
   logic                 disp_any, res_any;
   logic                 accept, load;
   logic                 unused_ok;

   always_comb begin
      idle_vec = '0;
      done_vec = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         idle_vec[k] = (state_q[k] == IDLE);
         done_vec[k] = (state_q[k] == DONE);
      end
   end

   rr_arbiter #(.N(NUM_UNITS)) u_disp_arb (
      .clk         (clk),
      .reset       (reset),
      .req_i       (idle_vec),
      .advance_i   (accept),
      .grant_o     (disp_gnt),
      .grant_idx_o (disp_idx),
      .any_o       (disp_any)
   );

   rr_arbiter #(.N(NUM_UNITS)) u_res_arb (
      .clk         (clk),
      .reset       (reset),
      .req_i       (done_vec),
      .advance_i   (load),
      .grant_o     (res_gnt),
      .grant_idx_o (res_idx),
      .any_o       (res_any)
   );

   assign o_ready = !reset && disp_any;
   assign accept  = i_valid && o_ready;
   assign load    = (!valid_q || i_ready) && res_any;

   always_comb begin
      state_d  = state_q;
      ray_d    = ray_q;
      base_d   = base_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      ivalid_d = '0;
      err_d    = err_q;
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (i_unit_finish[k] && state_q[k] != RUN) begin
            err_d = 1'b1;
         end
         case (state_q[k])
            IDLE: begin
               if (accept && disp_gnt[k]) begin
                  ray_d[k]           = i_ray;
                  base_d[k]          = cfg_baseaddr;
                  cnt_d[k]           = cfg_tri_cnt;
                  res_d[k].id        = ID_MAX_W'(i_ray_id);
                  res_d[k].hit       = 1'b0;
                  res_d[k].t         = '0;
                  res_d[k].tri_index = '0;
                  // An empty triangle list has a known miss result; skip the unit entirely.
                  if (cfg_tri_cnt == '0) begin
                     state_d[k] = DONE;
                  end else begin
                     state_d[k]  = RUN;
                     ivalid_d[k] = 1'b1;
                  end
               end
            end
            RUN: begin
               if (i_unit_finish[k]) begin
                  state_d[k]         = DONE;
                  res_d[k].hit       = i_unit_hit[k];
                  res_d[k].t         = i_unit_t[32*k +: 32];
                  res_d[k].tri_index = i_unit_tri_index[32*k +: 32];
               end
            end
            DONE: begin
               if (load && res_gnt[k]) begin
                  state_d[k] = IDLE;
               end
            end
            default: state_d[k] = IDLE;
         endcase
      end
   end

   always_comb begin
      valid_d = valid_q;
      out_d   = out_q;
      if (!valid_q || i_ready) begin
         valid_d = res_any;
         if (res_any) begin
            out_d = res_q[res_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_UNITS; k++) begin
            state_q[k] <= IDLE;
            ray_q[k]   <= '0;
            base_q[k]  <= '0;
            cnt_q[k]   <= '0;
            res_q[k]   <= '0;
         end
         ivalid_q <= '0;
         out_q    <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ray_q    <= ray_d;
         base_q   <= base_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         ivalid_q <= ivalid_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      o_unit_ray      = '0;
      o_unit_baseaddr = '0;
      o_unit_tri_cnt  = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         o_unit_ray[RAY_W*k +: RAY_W] = ray_q[k];
         o_unit_baseaddr[32*k +: 32]  = base_q[k];
         o_unit_tri_cnt[32*k +: 32]   = cnt_q[k];
      end
   end

   assign o_unit_ivalid = ivalid_q;
   assign o_valid       = valid_q;
   assign o_ray_id      = out_q.id[ID_W-1:0];
   assign o_hit         = out_q.hit;
   assign o_t           = out_q.t;
   assign o_tri_index   = out_q.tri_index;
   assign o_busy        = !(&idle_vec) || valid_q;
   assign o_err         = err_q;
   assign unused_ok     = ^{disp_idx, out_q.id};

endmodule
